// File: rtl/imem_loader.sv
// Instruction-memory image loader: length-framed byte stream in,
// big-endian 32-bit words out to imem, core held in reset until done.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int          CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             reload,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             core_hold,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [1:0] S_HDR  = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       idx;
   logic [23:0]      shreg;
   logic [31:0]      word;
   logic [CNT_W-1:0] len;
   logic [31:0]      hold_word;
   logic             hold_vld;
   logic             take;
   logic             last_byte;
   logic             restart;
   logic [CNT_W-1:0] cnt_nxt;

   assign take      = in_valid & in_ready;
   assign last_byte = take & (idx == 2'd3);
   assign word      = {shreg, in_data};
   assign cnt_nxt   = word_cnt + CNT_W'(1);
   assign restart   = reload & ((state == S_DONE) | (state == S_ERR));

   // Byte assembly: first three bytes of a word shift in, fourth completes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= 2'd0;
         shreg <= 24'd0;
      end else if (restart) begin
         idx   <= 2'd0;
      end else if (take) begin
         idx   <= idx + 2'd1;
         shreg <= {shreg[15:0], in_data};
      end
   end

   // Load sequencing, memory write from the holding register, status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_HDR;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'd0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         word_cnt  <= '0;
         len       <= '0;
         hold_word <= 32'd0;
         hold_vld  <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         // The holding register frees the assembler, so the next word's
         // bytes keep flowing during this write cycle.
         if (hold_vld) begin
            mem_we    <= 1'b1;
            mem_wdata <= hold_word;
            mem_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
            word_cnt  <= cnt_nxt;
            hold_vld  <= 1'b0;
            if (cnt_nxt == len) begin
               state    <= S_DONE;
               in_ready <= 1'b0;
            end
         end
         unique case (state)
            S_HDR: begin
               in_ready <= 1'b1;
               if (last_byte) begin
                  if (word == 32'd0 || word > MAX_WORDS) begin
                     state    <= S_ERR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                  end else begin
                     state <= S_DATA;
                     len   <= word[CNT_W-1:0];
                  end
               end
            end
            S_DATA: begin
               if (last_byte) begin
                  hold_word <= word;
                  hold_vld  <= 1'b1;
               end
            end
            S_DONE: begin
               done      <= 1'b1;
               core_hold <= 1'b0;
            end
            S_ERR: begin
            end
            default: begin
            end
         endcase
         if (restart) begin
            state     <= S_HDR;
            in_ready  <= 1'b1;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            word_cnt  <= '0;
            mem_addr  <= BASE_ADDR;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x0040_0000)
// share one stream; a scoreboard checks every memory write.
module tb_imem_loader;

   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0040_0000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       reload = 1'b0;

   logic        rdy0, we0, hold0, done0, err0;
   logic [31:0] addr0, wd0;
   logic [8:0]  cnt0;
   logic        rdy1, we1, hold1, done1, err1;
   logic [31:0] addr1, wd1;
   logic [8:0]  cnt1;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_acc = 0;
   int widx = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   imem_loader #(.BASE_ADDR(B0), .MAX_WORDS(256), .CNT_W(9)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .reload(reload), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wd0), .core_hold(hold0), .done(done0), .error(err0),
      .word_cnt(cnt0)
   );

   imem_loader #(.BASE_ADDR(B1), .MAX_WORDS(256), .CNT_W(9)) dut_hi (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .reload(reload), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wd1), .core_hold(hold1), .done(done1), .error(err1),
      .word_cnt(cnt1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every write must match the next expected entry
   always @(negedge clk) begin
      if (we0) begin
         if (q0.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL w0_unexpected: got write %h @%h expected none",
                     wd0, addr0);
         end else begin
            e0 = q0.pop_front();
            chk("w0_addr", addr0, e0.addr);
            chk("w0_data", wd0, e0.data);
            chk("w0_cycle", cyc, e0.cyc);
         end
      end
      if (we1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL w1_unexpected: got write %h @%h expected none",
                     wd1, addr1);
         end else begin
            e1 = q1.pop_front();
            chk("w1_addr", addr1, e1.addr);
            chk("w1_data", wd1, e1.data);
            chk("w1_cycle", cyc, e1.cyc);
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gaps);
      int t;
      repeat (gaps) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!rdy0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!rdy0) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 (byte %h)", b);
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] n);
      send(n[31:24], 0);
      send(n[23:16], 0);
      send(n[15:8], 0);
      send(n[7:0], 0);
      widx = 0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gaps);
      exp_t e;
      send(w[31:24], 0);
      send(w[23:16], gaps);
      send(w[15:8], gaps);
      send(w[7:0], gaps);
      e.data = w;
      e.cyc  = last_acc + 1;
      e.addr = B0 + 32'(widx * 4);
      q0.push_back(e);
      e.addr = B1 + 32'(widx * 4);
      q1.push_back(e);
      widx++;
   endtask

   task automatic pulse_reload(input logic with_valid);
      reload   = 1'b1;
      in_valid = with_valid;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
      reload   = 1'b0;
      in_valid = 1'b0;
      chk1("reload_in_ready", rdy0, 1'b1);
      chk1("reload_core_hold", hold0, 1'b1);
      chk1("reload_done", done0, 1'b0);
      chk1("reload_error", err0, 1'b0);
      chk("reload_word_cnt", 32'(cnt0), 0);
      chk("reload_mem_addr", addr0, B0);
   endtask

   task automatic check_done(input int n);
      @(posedge clk);
      #1;
      chk1("fin1_done", done0, 1'b0);
      chk1("fin1_core_hold", hold0, 1'b1);
      chk1("fin1_in_ready", rdy0, 1'b0);
      chk("fin1_word_cnt", 32'(cnt0), n);
      @(posedge clk);
      #1;
      chk1("fin2_done", done0, 1'b1);
      chk1("fin2_core_hold", hold0, 1'b0);
      chk1("fin2_done_hi", done1, 1'b1);
      chk("fin2_word_cnt", 32'(cnt0), n);
      chk("fin2_addr_hold", addr0, B0 + 32'((n - 1) * 4));
   endtask

   task automatic check_err();
      chk1("err_error", err0, 1'b1);
      chk1("err_in_ready", rdy0, 1'b0);
      chk1("err_core_hold", hold0, 1'b1);
      chk1("err_done", done0, 1'b0);
      in_data  = 8'h00;
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk1("err_in_ready_stays", rdy0, 1'b0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_in_ready", rdy0, 1'b0);
      chk1("rst_mem_we", we0, 1'b0);
      chk("rst_mem_addr", addr0, B0);
      chk("rst_mem_addr_hi", addr1, B1);
      chk("rst_mem_wdata", wd0, 32'd0);
      chk1("rst_core_hold", hold0, 1'b1);
      chk1("rst_done", done0, 1'b0);
      chk1("rst_error", err0, 1'b0);
      chk("rst_word_cnt", 32'(cnt0), 0);
      rst = 1'b1;
      #1;
      chk1("rel_in_ready_lo", rdy0, 1'b0);
      @(posedge clk);
      #1;
      chk1("rel_in_ready_hi", rdy0, 1'b1);

      // Two words back-to-back
      send_hdr(32'd2);
      send_word(32'h2008_0005, 0);
      send_word(32'h2009_0007, 0);
      check_done(2);

      // Bytes offered in DONE are never taken
      in_data  = 8'h55;
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk1("done_in_ready", rdy0, 1'b0);
         chk("done_word_cnt", 32'(cnt0), 2);
      end
      in_valid = 1'b0;

      // Reload with a simultaneous byte, then N = 1
      pulse_reload(1'b1);
      send_hdr(32'd1);
      send_word(32'hDEAD_BEEF, 0);
      check_done(1);

      // Illegal headers
      pulse_reload(1'b0);
      send_hdr(32'd0);
      check_err();
      pulse_reload(1'b0);
      send_hdr(32'h0000_0101);
      check_err();
      pulse_reload(1'b0);

      // Largest legal header is accepted
      send_hdr(32'd256);
      @(posedge clk);
      #1;
      chk1("max_error", err0, 1'b0);
      chk1("max_in_ready", rdy0, 1'b1);
      rst = 1'b0;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // N = 1 with idle gaps between bytes
      send_hdr(32'd1);
      send_word(32'h1234_5678, 2);
      check_done(1);

      // Four words: address sequence on both base addresses
      pulse_reload(1'b0);
      send_hdr(32'd4);
      send_word(32'h0000_0001, 0);
      send_word(32'hA5A5_5A5A, 0);
      send_word(32'hFFFF_FFFF, 1);
      send_word(32'h0102_0304, 0);
      check_done(4);

      // Reset in the middle of word 2 of 3
      pulse_reload(1'b0);
      send_hdr(32'd3);
      send_word(32'h1111_2222, 0);
      send(8'h33, 0);
      send(8'h44, 0);
      #1;
      rst = 1'b0;
      #1;
      chk1("mid_in_ready", rdy0, 1'b0);
      chk1("mid_mem_we", we0, 1'b0);
      chk("mid_mem_addr", addr0, B0);
      chk("mid_mem_wdata", wd0, 32'd0);
      chk1("mid_core_hold", hold0, 1'b1);
      chk1("mid_done", done0, 1'b0);
      chk("mid_word_cnt", 32'(cnt0), 0);
      chk("mid_queue_empty", 32'(q0.size()), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send_hdr(32'd2);
      send_word(32'hCAFE_F00D, 0);
      send_word(32'h0BAD_C0DE, 0);
      check_done(2);

      repeat (3) @(posedge clk);
      #1;
      chk("end_q0_empty", 32'(q0.size()), 0);
      chk("end_q1_empty", 32'(q1.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
